// File: rtl/sd_block_reader.sv
// sd_block_reader
// Captures one CMD17 data block (BLOCK_BYTES data bytes + 2 CRC bytes) from
// the SD controller byte stream into on-chip RAM, checks CRC16-CCITT
// (poly 0x1021, init 0, MSB-first), then replays the block over a
// valid/ready byte stream and reports pass/fail status.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   arm                   pulse: start capturing a new block (IDLE only)
//   byte_in, byte_valid   incoming byte and its one-cycle strobe
//   block_end             controller reports end of transfer
//   out_data, out_valid,
//   out_ready, out_last   replay stream; out_last marks the final byte
//   done                  one-cycle pulse at end of replay or on abort
//   crc_ok                received CRC matched, valid until next arm
//   err_short             sticky short-block error, cleared by arm
//   busy                  high in every state except IDLE
module sd_block_reader #(
   parameter int unsigned BLOCK_BYTES = 512,
   parameter int unsigned ADDR_W      = 9
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       arm,
   input  logic [7:0] byte_in,
   input  logic       byte_valid,
   input  logic       block_end,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       done,
   output logic       crc_ok,
   output logic       err_short,
   output logic       busy
);

   typedef enum logic [2:0] {IDLE, CAPTURE, CRC_HI, CRC_LO, CHECK, DRAIN} state_t;

   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(BLOCK_BYTES - 1);

   state_t          state, state_next;
   logic [ADDR_W:0] count;
   logic [ADDR_W:0] rd_ptr;
   logic [15:0]     crc_calc;
   logic [15:0]     crc_rx;
   logic [7:0]      mem [BLOCK_BYTES];

   logic abort;   // short-block termination
   logic wr_en;   // accept a data byte into the buffer
   logic load;    // fetch next byte into the output register
   logic fin;     // handshake of the final byte

   function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c ^ {d, 8'h00};
      for (int unsigned i = 0; i < 8; i++) begin
         r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
      end
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      abort      = 1'b0;
      wr_en      = 1'b0;
      load       = 1'b0;
      fin        = 1'b0;
      case (state)
         IDLE: begin
            if (arm) state_next = CAPTURE;
         end
         CAPTURE: begin
            if (block_end) begin
               abort      = 1'b1;
               state_next = IDLE;
            end else if (byte_valid) begin
               wr_en = 1'b1;
               if (count == LAST_IDX) state_next = CRC_HI;
            end
         end
         CRC_HI: begin
            if (block_end) begin
               abort      = 1'b1;
               state_next = IDLE;
            end else if (byte_valid) begin
               state_next = CRC_LO;
            end
         end
         CRC_LO: begin
            // A final CRC byte arriving with block_end completes the block.
            if (byte_valid) begin
               state_next = CHECK;
            end else if (block_end) begin
               abort      = 1'b1;
               state_next = IDLE;
            end
         end
         CHECK: state_next = DRAIN;
         DRAIN: begin
            // The output register doubles as the RAM read register: a new
            // byte is fetched when the register is empty or being consumed.
            if (!out_valid) begin
               load = 1'b1;
            end else if (out_ready) begin
               if (out_last) begin
                  fin        = 1'b1;
                  state_next = IDLE;
               end else begin
                  load = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[count[ADDR_W-1:0]] <= byte_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count     <= '0;
         rd_ptr    <= '0;
         crc_calc  <= '0;
         crc_rx    <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         done      <= 1'b0;
         crc_ok    <= 1'b0;
         err_short <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (arm) begin
                  count     <= '0;
                  crc_calc  <= '0;
                  crc_ok    <= 1'b0;
                  err_short <= 1'b0;
               end
            end
            CAPTURE: begin
               if (wr_en) begin
                  crc_calc <= crc16_byte(crc_calc, byte_in);
                  count    <= count + 1'b1;
               end
            end
            CRC_HI: if (byte_valid) crc_rx[15:8] <= byte_in;
            CRC_LO: if (byte_valid) crc_rx[7:0]  <= byte_in;
            CHECK: begin
               crc_ok <= (crc_calc == crc_rx);
               rd_ptr <= '0;
            end
            DRAIN: begin
               if (load) begin
                  out_data  <= mem[rd_ptr[ADDR_W-1:0]];
                  out_valid <= 1'b1;
                  out_last  <= (rd_ptr == LAST_IDX);
                  rd_ptr    <= rd_ptr + 1'b1;
               end else if (fin) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  done      <= 1'b1;
               end
            end
            default: ;
         endcase
         if (abort) begin
            err_short <= 1'b1;
            done      <= 1'b1;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_sd_block_reader.sv
// tb_sd_block_reader
// Directed self-checking bench for sd_block_reader: nominal block, bad CRC,
// backpressure, short blocks, CRC-phase boundaries, stray inputs,
// back-to-back arm and asynchronous reset during replay.
module tb_sd_block_reader;

   localparam int BB = 512;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       arm = 1'b0;
   logic [7:0] byte_in = 8'h00;
   logic       byte_valid = 1'b0;
   logic       block_end = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic       out_valid, out_last, done, crc_ok, err_short, busy;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_mem [BB];

   typedef struct {
      int got;
      int data_err;
      int first_bad;
      int last_err;
      int stab_err;
      int cycles;
      bit done_seen;
   } drain_res_t;

   sd_block_reader #(.BLOCK_BYTES(BB), .ADDR_W(9)) dut (
      .clk(clk), .rst_n(rst_n), .arm(arm), .byte_in(byte_in),
      .byte_valid(byte_valid), .block_end(block_end), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .done(done), .crc_ok(crc_ok), .err_short(err_short), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   // Bit-serial CRC16-CCITT over exp_mem[0..n-1].
   function automatic logic [15:0] crc_model(input int n);
      logic [15:0] c;
      logic        fb;
      c = 16'h0000;
      for (int i = 0; i < n; i++) begin
         for (int b = 7; b >= 0; b--) begin
            fb = c[15] ^ exp_mem[i][b];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
         end
      end
      return c;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      byte_in    = b;
      byte_valid = 1'b1;
      tick();
      byte_valid = 1'b0;
      tick();
   endtask

   task automatic send_data(input int n);
      for (int i = 0; i < n; i++) send_byte(exp_mem[i]);
   endtask

   // Consumes the replay stream; statistics only, comparisons are made by callers.
   task automatic drain(input int unsigned ready_pct, input int stop_at, output drain_res_t r);
      bit         held;
      logic [7:0] hd;
      logic       hl;
      r = '{default: 0};
      r.first_bad = -1;
      held = 1'b0;
      hd = 8'h00;
      hl = 1'b0;
      while (r.cycles < 4000) begin
         if (done) begin
            r.done_seen = 1'b1;
            break;
         end
         if (r.got == stop_at) break;
         if (held && (!out_valid || out_data !== hd || out_last !== hl)) r.stab_err++;
         out_ready = ($urandom_range(0, 99) < ready_pct);
         held = 1'b0;
         if (out_valid) begin
            if (out_ready) begin
               if (r.got >= BB || out_data !== exp_mem[r.got]) begin
                  r.data_err++;
                  if (r.first_bad < 0) r.first_bad = r.got;
               end
               if (out_last !== (r.got == BB - 1)) r.last_err++;
               r.got++;
            end else begin
               held = 1'b1;
               hd   = out_data;
               hl   = out_last;
            end
         end
         tick();
         r.cycles++;
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({out_data, out_valid, out_last, done, crc_ok, err_short, busy} !== 14'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %h required 0000", {out_data, out_valid, out_last, done, crc_ok, err_short, busy});
      end
      #1 rst_n = 1'b1;
      tick();
      tick();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b required 0", busy); end
   endtask

   task automatic test_nominal();
      drain_res_t r;
      for (int i = 0; i < BB; i++) exp_mem[i] = 8'hFF;
      do_arm();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL nominal_busy_capture: got %b required 1", busy); end
      send_data(BB);
      send_byte(8'h7F);
      send_byte(8'hA1);
      drain(100, -1, r);
      checks++;
      if (r.done_seen !== 1'b1) begin errors++; $display("FAIL nominal_done_seen: got %b required 1", r.done_seen); end
      checks++;
      if (r.got != BB) begin errors++; $display("FAIL nominal_count: got %0d required %0d", r.got, BB); end
      checks++;
      if (r.data_err != 0) begin errors++; $display("FAIL nominal_data: %0d bad bytes, first at %0d, required 0", r.data_err, r.first_bad); end
      checks++;
      if (r.last_err != 0) begin errors++; $display("FAIL nominal_last: %0d misplaced out_last, required 0", r.last_err); end
      checks++;
      if (crc_ok !== 1'b1) begin errors++; $display("FAIL nominal_crc_ok: got %b required 1", crc_ok); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL nominal_valid_after_last: got %b required 0", out_valid); end
      checks++;
      if (r.cycles > 2 * BB + 4) begin errors++; $display("FAIL nominal_throughput: took %0d cycles required <= %0d", r.cycles, 2 * BB + 4); end
      tick();
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL nominal_done_single: got %b required 0", done); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL nominal_busy_end: got %b required 0", busy); end
   endtask

   task automatic test_incrementing_bad_crc();
      drain_res_t r;
      for (int i = 0; i < BB; i++) exp_mem[i] = i[7:0];
      do_arm();
      send_data(BB);
      send_byte(8'h00);
      send_byte(8'h00);
      drain(100, -1, r);
      checks++;
      if (r.got != BB || r.done_seen !== 1'b1) begin errors++; $display("FAIL incr_count: got %0d done %b required %0d done 1", r.got, r.done_seen, BB); end
      checks++;
      if (r.data_err != 0 || r.last_err != 0) begin errors++; $display("FAIL incr_data: data_err %0d first %0d last_err %0d required 0", r.data_err, r.first_bad, r.last_err); end
      checks++;
      if (crc_ok !== 1'b0) begin errors++; $display("FAIL incr_crc_ok: got %b required 0", crc_ok); end
      checks++;
      if (err_short !== 1'b0) begin errors++; $display("FAIL incr_err_short: got %b required 0", err_short); end
      tick();
   endtask

   task automatic test_backpressure();
      drain_res_t r;
      logic [15:0] c;
      for (int i = 0; i < BB; i++) exp_mem[i] = 8'(i * 37 + 11);
      c = crc_model(BB);
      do_arm();
      send_data(BB);
      send_byte(c[15:8]);
      send_byte(c[7:0]);
      drain(30, -1, r);
      checks++;
      if (r.got != BB || r.done_seen !== 1'b1) begin errors++; $display("FAIL bp_count: got %0d done %b required %0d done 1", r.got, r.done_seen, BB); end
      checks++;
      if (r.data_err != 0 || r.last_err != 0) begin errors++; $display("FAIL bp_data: data_err %0d first %0d last_err %0d required 0", r.data_err, r.first_bad, r.last_err); end
      checks++;
      if (r.stab_err != 0) begin errors++; $display("FAIL bp_stable: %0d unstable stalled cycles required 0", r.stab_err); end
      checks++;
      if (crc_ok !== 1'b1) begin errors++; $display("FAIL bp_crc_ok: got %b required 1", crc_ok); end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_end: done %b busy %b required 0 0", done, busy); end
   endtask

   task automatic test_short_block();
      int v;
      int d;
      for (int i = 0; i < BB; i++) exp_mem[i] = 8'(i ^ 8'h55);
      do_arm();
      send_data(100);
      block_end = 1'b1;
      tick();
      block_end = 1'b0;
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL short_done: got %b required 1", done); end
      checks++;
      if (err_short !== 1'b1) begin errors++; $display("FAIL short_err: got %b required 1", err_short); end
      checks++;
      if (busy !== 1'b0 || crc_ok !== 1'b0) begin errors++; $display("FAIL short_idle: busy %b crc_ok %b required 0 0", busy, crc_ok); end
      v = 0;
      d = 0;
      out_ready = 1'b1;
      repeat (20) begin
         tick();
         if (out_valid) v++;
         if (done) d++;
      end
      out_ready = 1'b0;
      checks++;
      if (v != 0 || d != 0) begin errors++; $display("FAIL short_no_replay: valid cycles %0d extra done %0d required 0 0", v, d); end
      do_arm();
      checks++;
      if (err_short !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL short_rearm: err_short %b busy %b required 0 1", err_short, busy); end
      block_end = 1'b1;
      tick();
      block_end = 1'b0;
      checks++;
      if (done !== 1'b1 || err_short !== 1'b1) begin errors++; $display("FAIL short_zero_bytes: done %b err_short %b required 1 1", done, err_short); end
      tick();
   endtask

   task automatic test_crc_boundaries();
      drain_res_t r;
      logic [15:0] c;
      int v;
      for (int i = 0; i < BB; i++) exp_mem[i] = 8'(3 * i + 1);
      c = crc_model(BB);
      // Abort while waiting for the first CRC byte.
      do_arm();
      send_data(BB);
      block_end = 1'b1;
      tick();
      block_end = 1'b0;
      checks++;
      if (done !== 1'b1 || err_short !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL crchi_abort: done %b err %b busy %b required 1 1 0", done, err_short, busy); end
      v = 0;
      out_ready = 1'b1;
      repeat (10) begin
         tick();
         if (out_valid) v++;
      end
      out_ready = 1'b0;
      checks++;
      if (v != 0 || crc_ok !== 1'b0) begin errors++; $display("FAIL crchi_no_replay: valid cycles %0d crc_ok %b required 0 0", v, crc_ok); end
      // Last CRC byte coincides with block_end: block is complete.
      do_arm();
      send_data(BB);
      send_byte(c[15:8]);
      byte_in    = c[7:0];
      byte_valid = 1'b1;
      block_end  = 1'b1;
      tick();
      byte_valid = 1'b0;
      block_end  = 1'b0;
      tick();
      drain(100, -1, r);
      checks++;
      if (err_short !== 1'b0) begin errors++; $display("FAIL crclo_simul_err: got %b required 0", err_short); end
      checks++;
      if (r.got != BB || r.data_err != 0 || crc_ok !== 1'b1) begin errors++; $display("FAIL crclo_simul_replay: got %0d data_err %0d crc_ok %b required %0d 0 1", r.got, r.data_err, crc_ok, BB); end
      tick();
   endtask

   task automatic test_stray();
      drain_res_t r;
      logic [15:0] c;
      for (int i = 0; i < BB; i++) exp_mem[i] = 8'(~i) ^ 8'h3C;
      c = crc_model(BB);
      repeat (5) send_byte(8'h5A);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL stray_idle_busy: got %b required 0", busy); end
      do_arm();
      for (int i = 0; i < BB; i++) begin
         if (i == 10 || i == 300) arm = 1'b1;
         send_byte(exp_mem[i]);
         arm = 1'b0;
         if (i == 20) begin
            arm = 1'b1;
            tick();
            arm = 1'b0;
         end
      end
      send_byte(c[15:8]);
      send_byte(c[7:0]);
      fork
         drain(100, -1, r);
         begin
            repeat (3) begin
               tick();
               byte_in    = 8'hAA;
               byte_valid = 1'b1;
               tick();
               byte_valid = 1'b0;
            end
            block_end = 1'b1;
            tick();
            block_end = 1'b0;
         end
      join
      checks++;
      if (r.got != BB || r.done_seen !== 1'b1) begin errors++; $display("FAIL stray_count: got %0d done %b required %0d done 1", r.got, r.done_seen, BB); end
      checks++;
      if (r.data_err != 0 || r.last_err != 0) begin errors++; $display("FAIL stray_data: data_err %0d first %0d last_err %0d required 0", r.data_err, r.first_bad, r.last_err); end
      checks++;
      if (crc_ok !== 1'b1 || err_short !== 1'b0) begin errors++; $display("FAIL stray_status: crc_ok %b err_short %b required 1 0", crc_ok, err_short); end
      tick();
   endtask

   task automatic test_back_to_back();
      drain_res_t r;
      logic [15:0] c;
      for (int i = 0; i < BB; i++) exp_mem[i] = 8'(i >> 1);
      c = crc_model(BB);
      do_arm();
      send_data(BB);
      send_byte(c[15:8]);
      send_byte(c[7:0]);
      drain(100, -1, r);
      checks++;
      if (r.done_seen !== 1'b1 || crc_ok !== 1'b1) begin errors++; $display("FAIL b2b_first: done %b crc_ok %b required 1 1", r.done_seen, crc_ok); end
      do_arm();
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || crc_ok !== 1'b0) begin errors++; $display("FAIL b2b_arm_taken: busy %b done %b crc_ok %b required 1 0 0", busy, done, crc_ok); end
      for (int i = 0; i < BB; i++) exp_mem[i] = 8'(8'hC3 - i);
      c = crc_model(BB);
      send_data(BB);
      send_byte(c[15:8]);
      send_byte(c[7:0]);
      drain(100, -1, r);
      checks++;
      if (r.got != BB || r.data_err != 0 || crc_ok !== 1'b1) begin errors++; $display("FAIL b2b_second: got %0d data_err %0d crc_ok %b required %0d 0 1", r.got, r.data_err, crc_ok, BB); end
      tick();
   endtask

   task automatic test_async_reset();
      drain_res_t r;
      logic [15:0] c;
      for (int i = 0; i < BB; i++) exp_mem[i] = 8'(i * 5);
      c = crc_model(BB);
      do_arm();
      send_data(BB);
      send_byte(c[15:8]);
      send_byte(c[7:0]);
      drain(100, 200, r);
      checks++;
      if (r.got != 200 || out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre: got %0d valid %b required 200 1", r.got, out_valid); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({out_data, out_valid, out_last, done, crc_ok, err_short, busy} !== 14'h0) begin
         errors++;
         $display("FAIL arst_outputs: got %h required 0000", {out_data, out_valid, out_last, done, crc_ok, err_short, busy});
      end
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      for (int i = 0; i < BB; i++) exp_mem[i] = 8'(i * 11 + 7);
      c = crc_model(BB);
      do_arm();
      send_data(BB);
      send_byte(c[15:8]);
      send_byte(c[7:0]);
      drain(100, -1, r);
      checks++;
      if (r.got != BB || r.data_err != 0 || r.last_err != 0) begin errors++; $display("FAIL arst_replay: got %0d data_err %0d last_err %0d required %0d 0 0", r.got, r.data_err, r.last_err, BB); end
      checks++;
      if (crc_ok !== 1'b1 || r.done_seen !== 1'b1) begin errors++; $display("FAIL arst_status: crc_ok %b done %b required 1 1", crc_ok, r.done_seen); end
      tick();
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_incrementing_bad_crc();
      test_backpressure();
      test_short_block();
      test_crc_boundaries();
      test_stray();
      test_back_to_back();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
